// File: rtl/fp16_operand_loader_if.sv
// Byte-beat input stream and assembled operand-pair output stream of fp16_operand_loader.
// master drives beats and consumes pairs; slave is the loader itself.
interface fp16_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sync;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [7:0]  out_flags;

  modport master (
    output in_valid, in_sync, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_flags
  );

  modport slave (
    input  in_valid, in_sync, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_flags
  );
endinterface

// File: rtl/fp16_operand_loader.sv
// Assembles FP16 operand pairs from low/high byte beats into a 2-entry FIFO.
// Define OPERAND_CLASSIFY_EN to attach half-precision special-value flags to each pair.
module fp16_operand_loader (
  input  logic                  clk,
  input  logic                  rst,
  fp16_operand_loader_if.slave  bus
);

  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  phase_t      phase_q, phase_d;
  logic [7:0]  low_a, low_b;
  logic [15:0] mem_a [2];
  logic [15:0] mem_b [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        xfer, push, pop;
  logic [15:0] asm_a, asm_b;

  // A low beat is always welcome; a high beat needs a free FIFO slot.
  assign bus.in_ready  = (phase_q == PH_LOW) || (count < 2'd2);
  assign xfer          = bus.in_valid && bus.in_ready && !bus.in_sync;
  assign push          = xfer && (phase_q == PH_HIGH);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (count != 2'd0);
  assign asm_a         = {bus.in_a, low_a};
  assign asm_b         = {bus.in_b, low_b};
  assign bus.out_a     = mem_a[rd_ptr];
  assign bus.out_b     = mem_b[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH_LOW;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (bus.in_sync)
      phase_d = PH_LOW;
    else if (xfer)
      phase_d = (phase_q == PH_LOW) ? PH_HIGH : PH_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_a <= 8'h00;
      low_b <= 8'h00;
    end else if (xfer && (phase_q == PH_LOW)) begin
      low_a <= bus.in_a;
      low_b <= bus.in_b;
    end
  end

  // Simultaneous push and pop leaves count unchanged; the new pair queues behind the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_a[i] <= 16'h0000;
        mem_b[i] <= 16'h0000;
      end
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= asm_a;
        mem_b[wr_ptr] <= asm_b;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef OPERAND_CLASSIFY_EN
  logic [7:0] mem_f [2];

  // Returns {nan, inf, sub, zero}; sign does not matter.
  function automatic logic [3:0] classify(input logic [15:0] v);
    logic exp_max, exp_zero, mant_nz;
    exp_max  = &v[14:10];
    exp_zero = ~|v[14:10];
    mant_nz  = |v[9:0];
    return {exp_max & mant_nz, exp_max & ~mant_nz, exp_zero & mant_nz, exp_zero & ~mant_nz};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_f[i] <= 8'h00;
    end else if (push) begin
      mem_f[wr_ptr] <= {classify(asm_a), classify(asm_b)};
    end
  end

  assign bus.out_flags = mem_f[rd_ptr];
`else
  assign bus.out_flags = 8'h00;
`endif

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Scoreboard bench for fp16_operand_loader: a beat-level model pushes expected pairs,
// a monitor pops and compares them whenever the loader hands a pair over.
module tb_fp16_operand_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  f;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_operand_loader_if bus ();

  fp16_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pair_t      sb[$];
  int         checks = 0;
  int         passes = 0;
  bit         model_high = 1'b0;
  logic [7:0] model_la, model_lb;

  function automatic logic [3:0] classOf(input logic [15:0] v);
    if (v[14:10] == 5'd31) return (v[9:0] != 10'd0) ? 4'b1000 : 4'b0100;
    if (v[14:10] == 5'd0)  return (v[9:0] != 10'd0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [7:0] expFlags(input logic [15:0] a, input logic [15:0] b);
`ifdef OPERAND_CLASSIFY_EN
    return {classOf(a), classOf(b)};
`else
    return 8'h00;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One input cycle: drive, check handshake outputs against the model, then advance the model.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] a,
                               input logic [7:0] b, input logic rdy, output bit acc);
    bit    exp_ready;
    pair_t p;
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_sync   = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
    #1;
    exp_ready = !model_high || (sb.size() < 2);
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
    acc = 1'b0;
    if (s) begin
      model_high = 1'b0;
    end else if (v && exp_ready) begin
      acc = 1'b1;
      if (!model_high) begin
        model_la   = a;
        model_lb   = b;
        model_high = 1'b1;
      end else begin
        p.a = {a, model_la};
        p.b = {b, model_lb};
        p.f = expFlags(p.a, p.b);
        sb.push_back(p);
        model_high = 1'b0;
      end
    end
  endtask

  // rdy_mode 0/1 holds out_ready at that level; 2 randomises it and inserts idle cycles.
  task automatic sendPair(input logic [15:0] a, input logic [15:0] b, input int rdy_mode);
    bit   acc;
    logic v, r;
    for (int beat = 0; beat < 2; beat++) begin
      acc = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        v = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        r = (rdy_mode == 2) ? logic'($urandom_range(0, 1)) : logic'(rdy_mode[0]);
        if (beat == 0) applyStimulus(v, 1'b0, a[7:0], b[7:0], r, acc);
        else           applyStimulus(v, 1'b0, a[15:8], b[15:8], r, acc);
      end
      if (!acc) begin
        checks++;
        $display("[TB] FAIL beat_timeout: got no accept expected accept within 60 cycles");
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 30 && sb.size() != 0; t++)
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain_timeout: got %0d pairs left expected 0", sb.size());
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sync   = 1'b0;
    bus.out_ready = 1'b0;
    sb.delete();
    model_high = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_a", {16'd0, bus.out_a}, 32'd0);
    checkOutput("rst_out_b", {16'd0, bus.out_b}, 32'd0);
    checkOutput("rst_out_flags", {24'd0, bus.out_flags}, 32'd0);
  endtask

  // Monitor: samples just before the rising edge, when a pop is about to happen.
  always @(negedge clk) begin
    pair_t e;
    #3;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_pair: got %h/%h expected no pair", bus.out_a, bus.out_b);
      end else begin
        e = sb.pop_front();
        checkOutput("out_a", {16'd0, bus.out_a}, {16'd0, e.a});
        checkOutput("out_b", {16'd0, bus.out_b}, {16'd0, e.b});
        checkOutput("out_flags", {24'd0, bus.out_flags}, {24'd0, e.f});
      end
    end
  end

  initial begin
    bit          acc;
    logic [15:0] ra, rb;
    logic [7:0]  hi_pick [6];
    hi_pick[0] = 8'h00; hi_pick[1] = 8'h7C; hi_pick[2] = 8'h7E;
    hi_pick[3] = 8'h80; hi_pick[4] = 8'hFC; hi_pick[5] = 8'h3C;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sync   = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b0;
    doReset();

    $display("[TB] basic pair and specials");
    sendPair(16'h3E00, 16'h4200, 1);
    drain();
    sendPair(16'h7C00, 16'h8000, 1);
    sendPair(16'h7E00, 16'h0001, 1);
    drain();

    $display("[TB] backpressure");
    sendPair(16'h3C00, 16'h4000, 0);
    sendPair(16'h4400, 16'h4800, 0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 8'h4C, 8'h50, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 8'h4C, 8'h50, 1'b0, acc);
    drain();

    $display("[TB] simultaneous push and pop");
    sendPair(16'h5400, 16'h5800, 0);
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 8'h5C, 8'h60, 1'b1, acc);
    drain();

    $display("[TB] in_sync mid-pair");
    applyStimulus(1'b1, 1'b0, 8'hAA, 8'hBB, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, acc);
    drain();

    $display("[TB] reset mid-operation");
    sendPair(16'h3C00, 16'h4000, 0);
    sendPair(16'h4400, 16'h4800, 0);
    applyStimulus(1'b1, 1'b0, 8'h55, 8'h66, 1'b0, acc);
    doReset();
    sendPair(16'h3E00, 16'h4200, 1);
    drain();

    $display("[TB] randomised pairs");
    for (int i = 0; i < 120; i++) begin
      ra = {hi_pick[$urandom_range(0, 5)] ^ 8'($urandom_range(0, 1) << 7), 8'($urandom)};
      rb = ($urandom_range(0, 1) != 0) ? 16'($urandom) : {hi_pick[$urandom_range(0, 5)], 8'h00};
      sendPair(ra, rb, 2);
    end
    drain();

    $display("[TB] randomised raw beats with in_sync");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0),
                    8'($urandom), 8'($urandom), logic'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
